csr_axil_initiator: RTL and testbench
=====================================

CSR_AXIL_INITIATOR -- requirements
Module: csr_axil_initiator

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI-lite/request address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, data width in bits; only 32 supported, STRB width = DATA_WIDTH/8.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req_valid / req_ready  in / out  1 / 1  request handshake.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  ADDR_WIDTH  byte address.
REQ-009 req_wdata / req_wstrb  in  DATA_WIDTH / DATA_WIDTH/8  write payload.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-012 rsp_err  out  1  1 when bresp/rresp bit 1 set (SLVERR/DECERR).
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 AXI-lite master ports: awvalid/awready/awaddr/awprot, wvalid/wready/wdata/wstrb, bvalid/bready/bresp, arvalid/arready/araddr/arprot, rvalid/rready/rdata/rresp; standard directions and widths (prot 3, resp 2).

Function
REQ-015 Single outstanding transaction; states IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE.
REQ-016 req_ready = 1 only in IDLE; combinational from state, not from req_valid.
REQ-017 IDLE, req_valid && req_write: latch addr/wdata/wstrb, set aw_pend=w_pend=1, go WR_REQ.
REQ-018 IDLE, req_valid && !req_write: latch addr, go RD_REQ.
REQ-019 awvalid = aw_pend, wvalid = w_pend, registered, asserted the cycle after acceptance; AW and W independent.
REQ-020 aw_pend clears on awvalid&&awready; w_pend clears on wvalid&&wready; both clearing same cycle allowed.
REQ-021 WR_REQ -> WR_RSP in the cycle after both pend flags are 0; bready = 1 only in WR_RSP.
REQ-022 WR_RSP, bvalid: capture rsp_err = bresp[1], rsp_rdata = 0, go DONE.
REQ-023 RD_REQ: arvalid = 1 until arready; on handshake go RD_RSP; rready = 1 only in RD_RSP.
REQ-024 RD_RSP, rvalid: capture rdata into rsp_rdata, rsp_err = rresp[1], go DONE.
REQ-025 DONE: rsp_valid = 1, rsp_rdata/rsp_err stable; on rsp_ready go IDLE; no new request accepted in the same cycle.
REQ-026 valid signals, once asserted, held with payload stable until handshake (AXI rule).
REQ-027 awprot = arprot = 3'b000; awaddr/araddr = latched req_addr unmodified.
REQ-028 Minimum latency with always-ready slave and rsp_ready: write req accept -> rsp_valid in 4 cycles; read in 3 cycles.
REQ-029 Early slave response (bvalid before both AW/W done) ignored until WR_RSP; no deadlock since bready low.
REQ-030 EXOKAY (2'b01) treated as OKAY: rsp_err = 0.
REQ-031 No timeout; transaction waits indefinitely for slave.

Reset
REQ-032 rst asserted: state IDLE, aw_pend=w_pend=0, awvalid=wvalid=arvalid=bready=rready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0 while rst high.
REQ-033 Reset mid-transaction aborts silently; no response produced; first request after release starts cleanly.
REQ-034 Reset release synchronised externally; req_ready may rise on first clk edge after rst deasserts.

Verification
REQ-035 Write 0xDEADBEEF, strb 0xF, addr 0x10, slave always ready, bresp OKAY -> AW/W seen with exact values, rsp_valid after 4 cycles, rsp_err=0, rsp_rdata=0.
REQ-036 Read addr 0x24, slave returns rdata 0x12345678 rresp OKAY after 5-cycle arready delay -> rsp_rdata=0x12345678, rsp_err=0, arvalid held stable during wait.
REQ-037 Write with wready 3 cycles before awready, then awready; bvalid pre-asserted -> bready only after both, single response, no duplicate AW/W.
REQ-038 Read with rresp SLVERR and write with bresp DECERR -> rsp_err=1 both; EXOKAY -> rsp_err=0.
REQ-039 rsp_ready held low 10 cycles -> rsp_valid/data stable, req_ready=0, new req_valid ignored until after rsp handshake.
REQ-040 rst pulsed while in RD_RSP -> all outputs to reset values asynchronously, no rsp_valid, next read completes normally.

Source files
------------

// File: rtl/csr_axil_initiator.sv
// csr_axil_initiator: turns one CSR request at a time into an AXI-lite write (AW+W->B) or read (AR->R).
// Latency accept->rsp_valid 4 cycles write / 3 read; waits indefinitely on slave readiness and on rsp_ready.
module csr_axil_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arprot,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [DATA_WIDTH/8-1:0] wstrb;
    } req_hold_t;

    state_t    state_q;
    state_t    state_d;
    req_hold_t hold_q;
    logic      aw_pend;
    logic      w_pend;
    logic      ready_en;
    logic      accept;
    logic      unused_resp_bits;

    // ready_en keeps req_ready low until the first edge after reset release
    assign req_ready = (state_q == IDLE) && ready_en;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);

    assign awvalid = aw_pend;
    assign wvalid  = w_pend;
    assign awaddr  = hold_q.addr;
    assign awprot  = 3'b000;
    assign wdata   = hold_q.wdata;
    assign wstrb   = hold_q.wstrb;
    assign bready  = (state_q == WR_RSP);
    assign arvalid = (state_q == RD_REQ);
    assign araddr  = hold_q.addr;
    assign arprot  = 3'b000;
    assign rready  = (state_q == RD_RSP);

    // only bit 1 of a response distinguishes error (SLVERR/DECERR) from OKAY/EXOKAY
    assign unused_resp_bits = bresp[0] ^ rresp[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_write ? WR_REQ : RD_REQ;
            WR_REQ:  if (!aw_pend && !w_pend) state_d = WR_RSP;
            WR_RSP:  if (bvalid) state_d = DONE;
            RD_REQ:  if (arready) state_d = RD_RSP;
            RD_RSP:  if (rvalid) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                hold_q.addr <= req_addr;
                if (req_write) begin
                    hold_q.wdata <= req_wdata;
                    hold_q.wstrb <= req_wstrb;
                    aw_pend      <= 1'b1;
                    w_pend       <= 1'b1;
                end
            end
            // AW and W retire independently; either may complete first
            if (aw_pend && awready) aw_pend <= 1'b0;
            if (w_pend && wready)   w_pend  <= 1'b0;
            if (state_q == WR_RSP && bvalid) begin
                rsp_rdata <= '0;
                rsp_err   <= bresp[1];
            end
            if (state_q == RD_RSP && rvalid) begin
                rsp_rdata <= rdata;
                rsp_err   <= rresp[1];
            end
        end
    end

endmodule

// File: tb/tb_csr_axil_initiator.sv
// Bench for csr_axil_initiator: directed vector table, reset-abort sequence and randomized
// transactions, each run against an in-bench AXI-lite slave with programmable stalls.
module tb_csr_axil_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int n_checks = 0;
    int n_fail   = 0;

    csr_axil_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          r_dly;
        int          b_dly;
        bit          b_pre;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          rsp_hold;
        bit          keep_valid;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit write, logic [31:0] addr, logic [31:0] wd, logic [3:0] ws,
                                int aw, int w, int ar, int r, int b, bit bpre,
                                logic [1:0] resp, logic [31:0] rd, int hold, bit keep,
                                logic [31:0] erd, bit eerr, int elat);
        vec_t v;
        v.write = write; v.addr = addr; v.wdata = wd; v.wstrb = ws;
        v.aw_dly = aw; v.w_dly = w; v.ar_dly = ar; v.r_dly = r; v.b_dly = b; v.b_pre = bpre;
        v.resp = resp; v.rdata = rd; v.rsp_hold = hold; v.keep_valid = keep;
        v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = elat;
        return v;
    endfunction

    // Reference: response code and cycle count follow from the protocol rules and slave stalls alone.
    function automatic vec_t model(vec_t v);
        int m;
        v.exp_err   = (v.resp == 2'b10) || (v.resp == 2'b11);
        v.exp_rdata = v.write ? 32'h0 : v.rdata;
        if (v.write) begin
            m = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
            v.exp_lat = 4 + m + ((v.b_pre || v.b_dly <= 1) ? 0 : v.b_dly - 1);
        end else begin
            v.exp_lat = 3 + v.ar_dly + v.r_dly;
        end
        return v;
    endfunction

    task automatic run_txn(input int idx, input vec_t v);
        int s, aw_seen, w_seen, ar_seen, rsp_seen;
        int aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_at, w_at, ar_at, lat;
        bit pay_ok, order_ok, hold_ok, ctrl_ok, done;
        logic [31:0] got_rdata;
        logic        got_err;
        s = 0; aw_seen = 0; w_seen = 0; ar_seen = 0; rsp_seen = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        aw_at = 0; w_at = 0; ar_at = 0; lat = -1;
        pay_ok = 1; order_ok = 1; hold_ok = 1; ctrl_ok = 1; done = 0;
        got_rdata = '0; got_err = 1'b0;
        check($sformatf("t%0d_req_ready_idle", idx), req_ready, 1);
        req_valid = 1; req_write = v.write; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        bresp = v.resp; rresp = v.resp; rdata = v.rdata;
        bvalid = v.write && v.b_pre; rvalid = 0; rsp_ready = 0;
        awready = (v.aw_dly == 0); wready = (v.w_dly == 0); arready = (v.ar_dly == 0);
        tick();
        while (!done && s < 300) begin
            s++;
            if (v.keep_valid) begin
                req_valid = 1; req_write = 1'($urandom_range(0, 1)); req_addr = $urandom;
                req_wdata = $urandom; req_wstrb = 4'($urandom);
            end else begin
                req_valid = 0;
            end
            if (busy !== 1'b1 || req_ready !== 1'b0) ctrl_ok = 0;
            awready = (aw_seen >= v.aw_dly);
            if (awvalid) begin
                if (!v.write || awaddr !== v.addr || awprot !== 3'b000) pay_ok = 0;
                if (awready) begin aw_hs++; aw_at = s; end else aw_seen++;
            end
            wready = (w_seen >= v.w_dly);
            if (wvalid) begin
                if (!v.write || wdata !== v.wdata || wstrb !== v.wstrb) pay_ok = 0;
                if (wready) begin w_hs++; w_at = s; end else w_seen++;
            end
            arready = (ar_seen >= v.ar_dly);
            if (arvalid) begin
                if (v.write || araddr !== v.addr || arprot !== 3'b000) pay_ok = 0;
                if (arready) begin ar_hs++; ar_at = s; end else ar_seen++;
            end
            bvalid = v.write && (b_hs == 0) && (v.b_pre || (aw_hs > 0 && w_hs > 0 &&
                     s >= ((aw_at > w_at) ? aw_at : w_at) + 1 + v.b_dly));
            if (bready) begin
                if (!v.write || aw_hs == 0 || w_hs == 0) order_ok = 0;
                else if (bvalid) b_hs++;
            end
            rvalid = !v.write && (r_hs == 0) && (ar_hs > 0) && (s >= ar_at + 1 + v.r_dly);
            if (rready) begin
                if (v.write || ar_hs == 0) order_ok = 0;
                else if (rvalid) r_hs++;
            end
            if (rsp_valid) begin
                if (lat < 0) begin
                    lat = s; got_rdata = rsp_rdata; got_err = rsp_err;
                end else if (rsp_rdata !== got_rdata || rsp_err !== got_err) begin
                    hold_ok = 0;
                end
                rsp_ready = (rsp_seen >= v.rsp_hold);
                if (rsp_ready) begin done = 1; req_valid = 0; end else rsp_seen++;
            end else begin
                rsp_ready = 0;
            end
            tick();
        end
        rsp_ready = 0; bvalid = 0; rvalid = 0; req_valid = 0;
        check($sformatf("t%0d_completed", idx), done, 1);
        if (done) begin
            check($sformatf("t%0d_aw_count", idx), aw_hs, v.write ? 1 : 0);
            check($sformatf("t%0d_w_count", idx), w_hs, v.write ? 1 : 0);
            check($sformatf("t%0d_ar_count", idx), ar_hs, v.write ? 0 : 1);
            check($sformatf("t%0d_resp_count", idx), b_hs + r_hs, 1);
            check($sformatf("t%0d_payload", idx), pay_ok, 1);
            check($sformatf("t%0d_ready_order", idx), order_ok, 1);
            check($sformatf("t%0d_busy_noaccept", idx), ctrl_ok, 1);
            check($sformatf("t%0d_rsp_stable", idx), hold_ok, 1);
            check($sformatf("t%0d_rsp_rdata", idx), got_rdata, v.exp_rdata);
            check($sformatf("t%0d_rsp_err", idx), got_err, v.exp_err);
            check($sformatf("t%0d_latency", idx), lat, v.exp_lat);
            check($sformatf("t%0d_back_to_idle", idx), {rsp_valid, busy, req_ready}, 3'b001);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 0, 4);
        vecs[1] = mk(0, 32'h24, 32'h0, 4'h0, 0, 0, 5, 0, 0, 0, 2'b00, 32'h12345678, 0, 0, 32'h12345678, 0, 8);
        vecs[2] = mk(1, 32'h30, 32'hCAFEF00D, 4'h5, 3, 0, 0, 0, 0, 1, 2'b00, 32'h0, 0, 0, 32'h0, 0, 7);
        vecs[3] = mk(0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b10, 32'hA5A50001, 0, 0, 32'hA5A50001, 1, 3);
        vecs[4] = mk(1, 32'h48, 32'h11223344, 4'hC, 0, 0, 0, 0, 0, 0, 2'b11, 32'hFFFFFFFF, 0, 0, 32'h0, 1, 4);
        vecs[5] = mk(0, 32'h4C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b01, 32'h0BADCAFE, 0, 0, 32'h0BADCAFE, 0, 3);
        vecs[6] = mk(1, 32'h50, 32'h01020304, 4'h3, 0, 2, 0, 0, 2, 0, 2'b01, 32'h0, 0, 0, 32'h0, 0, 7);
        vecs[7] = mk(1, 32'h5C, 32'h89ABCDEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 10, 1, 32'h0, 0, 4);

        rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        #1;
        check("reset_ctrl_outputs",
              {req_ready, busy, awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err}, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        tick(); tick();
        rst = 0;
        tick();
        check("ready_after_release", req_ready, 1);

        for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

        // abort a read while it waits for R, then confirm a clean restart
        req_valid = 1; req_write = 0; req_addr = 32'h80; arready = 1; rvalid = 0;
        tick();
        req_valid = 0;
        tick();
        check("abort_in_rd_rsp", rready, 1);
        #2 rst = 1;
        #1;
        check("abort_async_ctrl",
              {req_ready, busy, awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err}, 0);
        check("abort_async_rdata", rsp_rdata, 0);
        arready = 0;
        tick(); tick();
        rst = 0;
        check("abort_no_rsp", {rsp_valid, busy}, 2'b00);
        tick();
        check("abort_ready_again", req_ready, 1);
        run_txn(50, mk(0, 32'h84, 32'h0, 4'h0, 0, 0, 1, 1, 0, 0, 2'b00, 32'h5555AAAA, 0, 0,
                       32'h5555AAAA, 0, 5));

        for (int i = 0; i < 30; i++) begin
            vec_t v;
            v.write = 1'($urandom_range(0, 1));
            v.addr = $urandom & 32'hFFFF_FFFC;
            v.wdata = $urandom;
            v.wstrb = 4'($urandom);
            v.aw_dly = $urandom_range(0, 4);
            v.w_dly = $urandom_range(0, 4);
            v.ar_dly = $urandom_range(0, 4);
            v.r_dly = $urandom_range(0, 4);
            v.b_dly = $urandom_range(0, 4);
            v.b_pre = 1'($urandom_range(0, 1));
            v.resp = 2'($urandom);
            v.rdata = $urandom;
            v.rsp_hold = $urandom_range(0, 3);
            v.keep_valid = 1'($urandom_range(0, 1));
            v = model(v);
            run_txn(100 + i, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
